// File: rtl/tow_judge.sv
// tow_judge: tug-of-war referee with synchronized, debounced buttons and latched wins.
// Define TOW_SCORE_EN to add saturating 4-bit win counters (scorel/scorer).
module tow_judge #(
  parameter int NLED = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen,
  input  logic            pbl,
  input  logic            pbr,
  output logic [NLED-1:0] leds,
  output logic            lwin,
  output logic            rwin
`ifdef TOW_SCORE_EN
  ,
  output logic [3:0]      scorel,
  output logic [3:0]      scorer
`endif
);

  localparam int PW = (NLED > 1) ? $clog2(NLED) : 1;
  localparam logic [PW-1:0] CENTRE  = PW'(NLED / 2);
  localparam logic [PW-1:0] LEFTEND = PW'(NLED - 1);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LWIN = 2'd1,
    RWIN = 2'd2
  } state_t;

  logic [1:0]    r_syncL;
  logic [1:0]    r_syncR;
  logic          r_sampL;
  logic          r_sampR;
  logic          r_evL;
  logic          r_evR;
  logic          r_restart;
  logic [PW-1:0] r_pos;
  state_t        r_state;

  logic          w_syncL;
  logic          w_syncR;
  logic [PW-1:0] w_posNext;
  state_t        w_stateNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_syncL <= 2'b00;
      r_syncR <= 2'b00;
    end else begin
      r_syncL <= {r_syncL[0], pbl};
      r_syncR <= {r_syncR[0], pbr};
    end
  end

  assign w_syncL = r_syncL[1];
  assign w_syncR = r_syncR[1];

  // Events and restart are one-cycle pulses, consumed by the FSM on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sampL   <= 1'b0;
      r_sampR   <= 1'b0;
      r_evL     <= 1'b0;
      r_evR     <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_evL     <= 1'b0;
      r_evR     <= 1'b0;
      r_restart <= 1'b0;
      if (slowen) begin
        r_sampL   <= w_syncL;
        r_sampR   <= w_syncR;
        r_evL     <= w_syncL & ~r_sampL;
        r_evR     <= w_syncR & ~r_sampR;
        r_restart <= w_syncL & w_syncR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PLAY;
      r_pos   <= CENTRE;
    end else begin
      r_state <= w_stateNext;
      r_pos   <= w_posNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_posNext   = r_pos;
    case (r_state)
      PLAY: begin
        if (r_evL && !r_evR) begin
          if (r_pos == LEFTEND) w_stateNext = LWIN;
          else                  w_posNext   = r_pos + PW'(1);
        end else if (r_evR && !r_evL) begin
          if (r_pos == '0) w_stateNext = RWIN;
          else             w_posNext   = r_pos - PW'(1);
        end
      end
      LWIN, RWIN: begin
        if (r_restart) begin
          w_stateNext = PLAY;
          w_posNext   = CENTRE;
        end
      end
      default: begin
        w_stateNext = PLAY;
        w_posNext   = CENTRE;
      end
    endcase
  end

  always_comb begin
    leds = NLED'(1) << r_pos;
    lwin = (r_state == LWIN);
    rwin = (r_state == RWIN);
  end

`ifdef TOW_SCORE_EN
  logic [3:0] r_scoreL;
  logic [3:0] r_scoreR;

  // Counters step only on the PLAY->win transition and survive restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scoreL <= 4'd0;
      r_scoreR <= 4'd0;
    end else begin
      if (r_state == PLAY && w_stateNext == LWIN && r_scoreL != 4'hF)
        r_scoreL <= r_scoreL + 4'd1;
      if (r_state == PLAY && w_stateNext == RWIN && r_scoreR != 4'hF)
        r_scoreR <= r_scoreR + 4'd1;
    end
  end

  assign scorel = r_scoreL;
  assign scorer = r_scoreR;
`endif

endmodule

// File: doc/tow_judge.md
TOW_JUDGE -- requirements
Module: tow_judge

Interface
REQ-001 Parameter NLED, default 7, number of position LEDs; SHALL be odd and >= 3.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 slowen  input  1  one-cycle sample-enable pulse from the clock-divider stage (slowen256 or slowen1024).
REQ-005 pbl  input  1  left-player push button, raw and asynchronous, 1 = pressed.
REQ-006 pbr  input  1  right-player push button, raw and asynchronous, 1 = pressed.
REQ-007 leds  output  NLED  one-hot rope position; bit NLED-1 is the left end.
REQ-008 lwin  output  1  1 while the left player holds a win.
REQ-009 rwin  output  1  1 while the right player holds a win.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Synchronized buttons SHALL be captured into sample registers only on edges where slowen=1; the registers hold between pulses (debounce).
REQ-012 A press event SHALL be sample_new=1 AND sample_old=0, evaluated only on slowen edges; a held button yields exactly one event.
REQ-013 Event latency: the position/state update SHALL occur on the clock edge one cycle after the slowen edge that produced the event.
REQ-014 Position register pos SHALL be ceil(log2(NLED)) bits, range 0..NLED-1, centre C=NLED/2 (integer division); leds = 1<<pos.
REQ-015 States SHALL be PLAY, LWIN and RWIN; LWIN and RWIN latch until restart.
REQ-016 PLAY, left event only: pos<NLED-1 -> pos+1; pos=NLED-1 -> LWIN, pos unchanged.
REQ-017 PLAY, right event only: pos>0 -> pos-1; pos=0 -> RWIN, pos unchanged.
REQ-018 PLAY, left and right events on the same slowen edge: no movement and no state change.
REQ-019 LWIN/RWIN: single-button events SHALL be ignored and leds SHALL hold the winning end position.
REQ-020 LWIN/RWIN restart: both sample registers =1 on a slowen edge (levels, not events) -> PLAY with pos=C on the next edge.
REQ-021 lwin=1 iff state=LWIN; rwin=1 iff state=RWIN; never both.
REQ-022 slowen=0 on every edge: the synchronizers still track the buttons; sample registers, pos and state SHALL NOT change.

Reset
REQ-023 rst=0 SHALL immediately clear both synchronizers and both sample registers to 0, set state=PLAY and pos=C; leds=1<<C, lwin=0, rwin=0.
REQ-024 Reset asserted mid-game or during a win SHALL abort to the REQ-023 values with no pending event surviving.
REQ-025 A button already held at reset release SHALL produce one event at the first slowen edge after its synchronized value reaches the sample register.

Configuration
REQ-026 Macro TOW_SCORE_EN defined: add outputs scorel[3:0] and scorer[3:0].
REQ-027 With TOW_SCORE_EN, each counter SHALL increment by 1 on entry to LWIN or RWIN respectively, saturate at 15, and survive restart.
REQ-028 With TOW_SCORE_EN, both counters SHALL clear only on rst=0.
REQ-029 Macro TOW_SCORE_EN undefined: no score ports and no score logic.

Verification
REQ-030 NLED=7, reset release, slowen every 4 clocks -> leds=0001000, lwin=0, rwin=0.
REQ-031 Left pulse spanning one slowen, repeated 3 times -> leds 0010000, 0100000, 1000000; 4th pulse -> lwin=1, leds=1000000.
REQ-032 Both buttons pressed together on the same slowen edge from centre -> leds stays 0001000.
REQ-033 pbl held for 20 slowen pulses -> exactly one move, leds=0010000.
REQ-034 In RWIN: pbr alone -> no change; both held over one slowen edge -> PLAY, leds=0001000; with TOW_SCORE_EN, scorer=1.
REQ-035 Glitch shorter than 2 clocks between slowen pulses -> no move; rst=0 mid-game at pos=5 -> leds=0001000 asynchronously.
